// File: rtl/i2c_target.sv
// I2C target endpoint: acknowledges TGT_ADDR, captures 16-bit write words and serialises 16-bit read words.
// Optional build macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter after each input synchronizer.
module i2c_target #(
  parameter logic [6:0] TGT_ADDR = 7'h55
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCL,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  output logic        SDA_OUT,
  input  logic [15:0] TX_DATA,
  output logic        TX_STB,
  output logic [15:0] RX_DATA,
  output logic        RX_STB,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c;
  logic       scl_prev_q, sda_prev_q;

  // NOTE: synchronizer and history flops reset to 1 (idle bus level) so reset release never looks like START/STOP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA_IN};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic        byte_cnt_q;
  logic        rw_q;
  logic [6:0]  shift_q;
  logic [15:0] shadow_q, tx_q, rx_data_q;
  logic        rx_stb_q, tx_stb_q, busy_q, sda_oe_q, sda_out_q;

  logic [7:0]  shift_d, rd_byte;
  logic        rd_bit;

  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    shift_d = {shift_q, sda_c};
    rd_byte = byte_cnt_q ? tx_q[7:0] : tx_q[15:8];
    rd_bit  = rd_byte[~bit_cnt_q[2:0]];
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= 1'b0;
      rw_q       <= 1'b0;
      shift_q    <= '0;
      shadow_q   <= '0;
      tx_q       <= '0;
      rx_data_q  <= '0;
      rx_stb_q   <= 1'b0;
      tx_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      sda_out_q  <= 1'b1;
    end else begin
      rx_stb_q <= 1'b0;
      tx_stb_q <= 1'b0;
      if (stop_det) begin
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        sda_out_q <= 1'b1;
        busy_q    <= 1'b0;
      end else if (start_det) begin
        state_q    <= ADDR;
        bit_cnt_q  <= '0;
        byte_cnt_q <= 1'b0;
        shadow_q   <= '0;
        sda_oe_q   <= 1'b0;
        sda_out_q  <= 1'b1;
      end else begin
        unique case (state_q)
          ADDR: if (scl_rise) begin
            shift_q   <= shift_d[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              if (shift_d[7:1] == TGT_ADDR) begin
                state_q <= ADDR_ACK;
                rw_q    <= shift_d[0];
                busy_q  <= 1'b1;
                if (shift_d[0]) begin
                  tx_q     <= TX_DATA;
                  tx_stb_q <= 1'b1;
                end
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          // The first fall starts the ACK bit, the second one ends it.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q  <= 1'b1;
              sda_out_q <= 1'b0;
            end else if (rw_q) begin
              state_q   <= RD_BYTE;
              sda_out_q <= rd_bit;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else begin
              state_q   <= WR_BYTE;
              sda_oe_q  <= 1'b0;
              sda_out_q <= 1'b1;
            end
          end
          WR_BYTE: if (scl_rise) begin
            shift_q   <= shift_d[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              state_q   <= WR_ACK;
              if (byte_cnt_q) shadow_q[7:0]  <= shift_d;
              else            shadow_q[15:8] <= shift_d;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q  <= 1'b1;
              sda_out_q <= 1'b0;
            end else begin
              sda_oe_q  <= 1'b0;
              sda_out_q <= 1'b1;
              if (byte_cnt_q) begin
                rx_data_q <= shadow_q;
                rx_stb_q  <= 1'b1;
                state_q   <= WAIT_STOP;
              end else begin
                byte_cnt_q <= 1'b1;
                state_q    <= WR_BYTE;
              end
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_q  <= 1'b0;
              sda_out_q <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= RD_ACK;
            end else begin
              sda_oe_q  <= 1'b1;
              sda_out_q <= rd_bit;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          RD_ACK: if (scl_rise) begin
            if (!sda_c && !byte_cnt_q) begin
              byte_cnt_q <= 1'b1;
              state_q    <= RD_BYTE;
            end else begin
              state_q <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDA_OE  = sda_oe_q;
  assign SDA_OUT = sda_out_q;
  assign TX_STB  = tx_stb_q;
  assign RX_DATA = rx_data_q;
  assign RX_STB  = rx_stb_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-level initiator drives directed and random transactions
// while a transaction-level model predicts ACKs, read bytes, strobes and the held RX word.
module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h55;
`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_drv = 1'b1;
  logic        sda_drv = 1'b1;
  logic [15:0] tx_data = 16'h0000;
  logic        sda_bus;
  logic        sda_oe, sda_out, tx_stb, rx_stb, busy;
  logic [15:0] rx_data;

  // Wired-AND open-drain bus: either side pulling low wins.
  assign sda_bus = sda_drv & (sda_oe ? sda_out : 1'b1);

  always #5 clk = ~clk;

  i2c_target #(.TGT_ADDR(TGT)) dut (
    .CLK    (clk),
    .RST    (rst_n),
    .SCL    (scl_drv),
    .SDA_IN (sda_bus),
    .SDA_OE (sda_oe),
    .SDA_OUT(sda_out),
    .TX_DATA(tx_data),
    .TX_STB (tx_stb),
    .RX_DATA(rx_data),
    .RX_STB (rx_stb),
    .BUSY   (busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_rx_q[$];
  logic [15:0] model_rx = 16'h0000;
  int          tx_pending = 0;
  bit          model_known = 1'b1;
  bit          oe_forbid = 1'b0;
  bit          busy_forbid = 1'b0;
  bit          glitch_arm = 1'b0;
  bit          glitch_seen = 1'b0;
  logic [15:0] glitch_val = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model: strobe widths, strobe legality, held RX word, quiet bus.
  initial begin
    bit rx_prev = 1'b0;
    bit tx_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rx_stb) begin
          check("rx_stb_single", rx_prev, 0);
          if (glitch_arm) begin
            glitch_seen = 1'b1;
            glitch_val  = rx_data;
          end
          if (model_known) begin
            if (exp_rx_q.size() == 0) check("rx_stb_unexpected", rx_stb, 0);
            else begin
              model_rx = exp_rx_q.pop_front();
              check("rx_data_on_stb", rx_data, model_rx);
            end
          end
        end else if (model_known) begin
          check("rx_data_hold", rx_data, model_rx);
        end
        if (tx_stb) begin
          check("tx_stb_single", tx_prev, 0);
          if (tx_pending == 0) check("tx_stb_unexpected", tx_stb, 0);
          else tx_pending--;
        end
        if (oe_forbid)   check("sda_oe_quiet", sda_oe, 0);
        if (busy_forbid) check("busy_quiet", busy, 0);
        rx_prev = rx_stb;
        tx_prev = tx_stb;
      end else begin
        rx_prev = 1'b0;
        tx_prev = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    int h;
    h = $urandom_range(10, 13);
    wait_clk(h / 2);
    sda_drv = b;
    wait_clk(h - h / 2);
    scl_drv = 1'b1;
    if (glitch) begin
      wait_clk(4);
      scl_drv = 1'b0;
      wait_clk(1);
      scl_drv = 1'b1;
      wait_clk(h - 5);
    end else begin
      wait_clk(h);
    end
    scl_drv = 1'b0;
  endtask

  task automatic recv_bit(output bit b);
    int h;
    h = $urandom_range(10, 13);
    wait_clk(h / 2);
    sda_drv = 1'b1;
    wait_clk(h - h / 2);
    scl_drv = 1'b1;
    wait_clk(h / 2);
    b = sda_bus;
    wait_clk(h - h / 2);
    scl_drv = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack, input int glitch_bit);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input bit ack);
    bit v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(v);
      d[i] = v;
    end
    send_bit(ack, 1'b0);
  endtask

  task automatic bus_start();
    wait_clk(10);
    sda_drv = 1'b0;
    wait_clk(10);
    scl_drv = 1'b0;
  endtask

  task automatic rep_start();
    wait_clk(6);
    sda_drv = 1'b1;
    wait_clk(6);
    scl_drv = 1'b1;
    wait_clk(10);
    sda_drv = 1'b0;
    wait_clk(10);
    scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(6);
    sda_drv = 1'b0;
    wait_clk(6);
    scl_drv = 1'b1;
    wait_clk(10);
    sda_drv = 1'b1;
    wait_clk(10);
  endtask

  // Write model: target ACKs its address and the first two data bytes; the word lands only after two bytes.
  task automatic txn_write(input logic [6:0] a, input int n, input logic [31:0] payload);
    bit match;
    bit ack;
    match = (a == TGT);
    if (!match) begin
      oe_forbid   = 1'b1;
      busy_forbid = 1'b1;
    end
    if (match && n >= 2) exp_rx_q.push_back(payload[31:16]);
    bus_start();
    write_byte({a, 1'b0}, ack, -1);
    check("wr_addr_ack", ack, match ? 0 : 1);
    if (match) check("busy_after_addr", busy, 1);
    for (int i = 0; i < n; i++) begin
      write_byte(payload[31 - 8 * i -: 8], ack, -1);
      check("wr_data_ack", ack, (match && i < 2) ? 0 : 1);
    end
    bus_stop();
    wait_clk(8);
    check("busy_after_stop", busy, 0);
    check("rx_stb_count", exp_rx_q.size(), 0);
    oe_forbid   = 1'b0;
    busy_forbid = 1'b0;
  endtask

  // Read model: target serves word[15:8] then word[7:0]; after a NACK or the second byte the bus reads 1s.
  task automatic txn_read(input logic [6:0] a, input int n, input bit nack_first,
                          input logic [15:0] word, output logic [15:0] got);
    bit          match;
    bit          ack;
    bit          driving;
    bit          ack_i;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    match = (a == TGT);
    got   = 16'hFFFF;
    tx_data = word;
    if (match) tx_pending++;
    else begin
      oe_forbid   = 1'b1;
      busy_forbid = 1'b1;
    end
    bus_start();
    write_byte({a, 1'b1}, ack, -1);
    check("rd_addr_ack", ack, match ? 0 : 1);
    if (match) check("busy_after_addr", busy, 1);
    tx_data = 16'($urandom);
    driving = match;
    for (int i = 0; i < n; i++) begin
      ack_i = (i == n - 1) ? 1'b1 : ((i == 0) ? nack_first : 1'b0);
      read_byte(d, ack_i);
      exp_d = (driving && i < 2) ? ((i == 0) ? word[15:8] : word[7:0]) : 8'hFF;
      check("rd_data", d, exp_d);
      if (i < 2) got[15 - 8 * i -: 8] = d;
      driving = driving && !ack_i && (i == 0);
    end
    check("sda_released_after_read", sda_oe, 0);
    bus_stop();
    wait_clk(8);
    check("busy_after_stop", busy, 0);
    check("tx_stb_count", tx_pending, 0);
    oe_forbid   = 1'b0;
    busy_forbid = 1'b0;
  endtask

  task automatic apply_reset();
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    rst_n   = 1'b0;
    wait_clk(3);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_sda_out", sda_out, 1);
    check("reset_rx_data", rx_data, 16'h0000);
    check("reset_rx_stb", rx_stb, 0);
    check("reset_tx_stb", tx_stb, 0);
    check("reset_busy", busy, 0);
    exp_rx_q.delete();
    model_rx    = 16'h0000;
    tx_pending  = 0;
    model_known = 1'b1;
    rst_n = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    logic [15:0] got;
    logic [7:0]  d;
    logic [6:0]  a;
    bit          ack;
    bit          found;
    bit          ok;

    apply_reset();

    txn_write(TGT, 2, 32'hBEEF_0000);
    check("write_word_literal", rx_data, 16'hBEEF);

    txn_read(TGT, 2, 1'b0, 16'h1234, got);
    check("read_word_literal", got, 16'h1234);

    txn_write(7'h54, 2, 32'h1122_0000);

    txn_write(TGT, 1, 32'hDE00_0000);
    check("abort_keeps_rx", rx_data, 16'hBEEF);

    // Write interrupted by a repeated START into a read.
    bus_start();
    write_byte(8'hAA, ack, -1);
    check("rs_addr_ack", ack, 0);
    write_byte(8'hCA, ack, -1);
    check("rs_data_ack", ack, 0);
    rep_start();
    tx_data = 16'hA5C3;
    tx_pending++;
    write_byte(8'hAB, ack, -1);
    check("rs_rd_addr_ack", ack, 0);
    tx_data = 16'h0F0F;
    read_byte(d, 1'b0);
    check("rs_rd_hi", d, 8'hA5);
    read_byte(d, 1'b1);
    check("rs_rd_lo", d, 8'hC3);
    bus_stop();
    wait_clk(8);
    check("rs_rx_kept", rx_data, 16'hBEEF);
    check("rs_tx_stb_count", tx_pending, 0);

    for (int t = 0; t < 18; t++) begin
      a = ($urandom_range(0, 3) != 0) ? TGT : 7'($urandom_range(0, 127));
      if (a != TGT && $urandom_range(0, 3) == 0) a = TGT ^ 7'h01;
      if ($urandom_range(0, 1) == 0)
        txn_write(a, $urandom_range(1, 3), $urandom);
      else
        txn_read(a, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 16'($urandom), got);
    end

    // One-CLK SCL low pulse during the first data byte.
    model_known = 1'b0;
    glitch_seen = 1'b0;
    glitch_arm  = 1'b1;
    bus_start();
    write_byte(8'hAA, ack, -1);
    write_byte(8'h5A, ack, 5);
    write_byte(8'h3C, ack, -1);
    bus_stop();
    wait_clk(20);
    glitch_arm = 1'b0;
    ok = glitch_seen && (glitch_val == 16'h5A3C);
    check("glitch_word_received", ok, FILT);

    apply_reset();

    // Reset while the target pulls SDA low in the first read bit.
    tx_data = 16'h1234;
    tx_pending++;
    bus_start();
    write_byte(8'hAB, ack, -1);
    check("rst_rd_addr_ack", ack, 0);
    wait_clk(8);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (sda_oe && !sda_out) found = 1'b1;
      else wait_clk(1);
    end
    check("rst_rd_drive_low", found, 1);
    check("rst_tx_stb_count", tx_pending, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_sda_oe", sda_oe, 0);
    check("async_rst_sda_out", sda_out, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_rx", rx_data, 16'h0000);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
